apb_dual_master_arbiter: RTL and testbench
==========================================

// Module: apb_dual_master_arbiter
// PURPOSE
// - Shares one APB3 slave bus (16 one-hot PSEL slots) between two requesters: port 0 (AHB-APB bridge side) and port 1 (BFM/debug side).
// - Round-robin arbitration; sequences the APB SETUP/ACCESS phases for each transfer.
// - Returns read data, completion and slave error to the granted requester.
// - Sits between the requester logic and the PSEL/PADDR/PENABLE fabric in the peripheral subsystem.
// PARAMETERS
// - SLOT_LSB        24   lowest address bit of the 4-bit slot field; slot = ADDRx[SLOT_LSB+3:SLOT_LSB]
// - TIMEOUT_CYCLES  255  ACCESS-phase wait limit; used only with APB_TIMEOUT_EN; legal range 1..1023
// PORTS
// - PCLK      in   1   clock, all logic on rising edge
// - PRESETN   in   1   asynchronous active-low reset
// - REQ0/REQ1     in   1   transfer request; held high until the matching ACK
// - WRITE0/WRITE1 in   1   1 = write, 0 = read; stable while REQ is high
// - ADDR0/ADDR1   in   32  byte address; stable while REQ is high
// - WDATA0/WDATA1 in   32  write data; stable while REQ is high
// - ACK0/ACK1     out  1   one-cycle completion pulse
// - RDATA0/RDATA1 out  32  read data, valid while ACK is high
// - ERR0/ERR1     out  1   slave error, valid while ACK is high
// - GRANT     out  2   one-hot owner of the current transfer; 00 when idle
// - PSEL      out  16  one-hot slave select
// - PADDR     out  32  latched address
// - PENABLE   out  1   APB access phase
// - PWRITE    out  1   APB direction
// - PWDATA    out  32  latched write data
// - PRDATA    in   32  slave read data
// - PREADY    in   1   slave ready
// - PSLVERR   in   1   slave error
// BEHAVIOUR
// - Reset values: all outputs 0; FSM in IDLE; round-robin pointer favours port 0.
// - Reset mid-transfer: outputs clear asynchronously; the transfer is abandoned and no ACK is issued.
// - FSM states: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
// - IDLE:
//   - If any REQ is high, pick a winner and register ADDR, WRITE and WDATA into PADDR, PWRITE and PWDATA.
//   - Set GRANT and go to SETUP.
//   - A REQx is ignored in any cycle where ACKx is high.
// - Arbitration:
//   - Only one REQ high: that port wins.
//   - Both high: the port not served last wins; after reset, port 0 wins.
//   - The pointer updates on every grant.
// - SETUP: PSEL[slot]=1, PENABLE=0, for exactly one cycle; then go to ACCESS.
// - ACCESS:
//   - PSEL held, PENABLE=1.
//   - PREADY=0: stay; PADDR, PWDATA and PWRITE are held.
//   - PREADY=1: register PRDATA (reads only; writes return 0) and PSLVERR; go to DONE.
// - DONE:
//   - PSEL=0, PENABLE=0.
//   - ACKx=1 for the granted port with RDATAx and ERRx valid; the other port's outputs stay 0.
//   - RDATAx and ERRx return to 0 the next cycle.
//   - GRANT clears; go to IDLE.
// - Latency with zero wait states:
//   - Request seen in IDLE at cycle N: SETUP at N+1, ACCESS at N+2, ACK at N+3.
//   - Each PREADY wait cycle adds 1.
//   - Minimum spacing between transfers is 4 cycles.
// - A request arriving in any non-IDLE state waits; there is no preemption.
// - PSEL is never multi-hot and PENABLE is never high without PSEL.
// CONFIGURATION
// - APB_TIMEOUT_EN defined:
//   - A 10-bit counter counts ACCESS cycles with PREADY=0.
//   - When the count reaches TIMEOUT_CYCLES, go to DONE with ERR=1 and RDATA=0.
//   - The counter clears in SETUP.
// - APB_TIMEOUT_EN undefined: ACCESS waits on PREADY indefinitely; no counter is synthesised.
// TESTING
// - Read port 0:
//   - Stimulus: ADDR0=0x0300_0010, PREADY tied 1, PRDATA=0xCAFE_F00D.
//   - Response: PSEL=0x0008 for 2 cycles, PENABLE only in the 2nd; ACK0 3 cycles after the request with RDATA0=0xCAFE_F00D and ERR0=0.
// - Write port 1:
//   - Stimulus: ADDR1=0x0F00_0004, WDATA1=0x1234_5678, PREADY low for 3 ACCESS cycles.
//   - Response: PSEL=0x8000 and PWDATA stable throughout; ACK1 at request+6; PRDATA ignored.
// - Contention:
//   - Stimulus: REQ0 and REQ1 raised in the same cycle after reset and held.
//   - Response: grants alternate 0,1,0,1; each ACK pulses once per transfer; GRANT is never 11.
// - Slave error:
//   - Stimulus: PSLVERR=1 together with PREADY on a port 0 read.
//   - Response: ERR0=1 with ACK0; the next transfer returns ERR0=0.
// - Reset mid-ACCESS:
//   - Stimulus: PRESETN low while PREADY=0.
//   - Response: PSEL, PENABLE and GRANT are 0 immediately; no ACK; after release REQ0 is served from IDLE.
// - Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=4):
//   - Stimulus: PREADY held 0.
//   - Response: ACK0 with ERR0=1 and RDATA0=0 after 4 ACCESS cycles.
//   - Without the macro, no ACK appears within 1000 cycles.

Source files
------------

// File: rtl/apb_dual_master_arbiter_if.sv
// apb_dual_master_arbiter_if: requester and APB3 bus signals for the dual-master arbiter
//   master modport: arbiter view (takes req/write/addr/wdata and prdata/pready/pslverr;
//                   drives ack/rdata/err/grant and psel/paddr/penable/pwrite/pwdata)
//   slave modport : environment view (requesters plus APB slave fabric)
interface apb_dual_master_arbiter_if;
    logic        req0, req1, write0, write1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [1:0]  grant;
    logic [15:0] psel;
    logic [31:0] paddr, pwdata, prdata;
    logic        penable, pwrite, pready, pslverr;
    modport master (
        input  req0, req1, write0, write1, addr0, addr1, wdata0, wdata1, prdata, pready, pslverr,
        output ack0, ack1, err0, err1, rdata0, rdata1, grant, psel, paddr, penable, pwrite, pwdata
    );
    modport slave (
        output req0, req1, write0, write1, addr0, addr1, wdata0, wdata1, prdata, pready, pslverr,
        input  ack0, ack1, err0, err1, rdata0, rdata1, grant, psel, paddr, penable, pwrite, pwdata
    );
endinterface

// File: rtl/apb_dual_master_arbiter.sv
// apb_dual_master_arbiter: round-robin sharing of one APB3 bus (16 one-hot slots) between two requesters
//   i_pclk    : clock, rising edge
//   i_presetn : asynchronous active-low reset
//   bus       : apb_dual_master_arbiter_if.master (requester ports 0/1 and APB master signals)
//   Optional macro APB_TIMEOUT_EN: ACCESS phase aborts with ERR after TIMEOUT_CYCLES not-ready cycles.
module apb_dual_master_arbiter #(
    parameter int SLOT_LSB       = 24,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                       i_pclk,
    input logic                       i_presetn,
    apb_dual_master_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    state_t      r_state, w_state;
    logic        r_last, w_last, r_pwrite, w_pwrite, r_err, w_err, w_win, w_ack0, w_ack1;
    logic [1:0]  r_grant, w_grant;
    logic [31:0] r_paddr, w_paddr, r_pwdata, w_pwdata, r_rdata, w_rdata;
    logic [3:0]  w_slot;
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..1023");
    end
`ifdef APB_TIMEOUT_EN
    localparam logic [9:0] TO_LIM = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0] r_tcnt, w_tcnt;
`endif
    // r_last is the port served last; resetting it to 1 hands the first contended grant to port 0.
    always_ff @(posedge i_pclk or negedge i_presetn) begin
        if (!i_presetn) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
            r_grant  <= '0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_tcnt   <= '0;
`endif
        end else begin
            r_state  <= w_state;
            r_last   <= w_last;
            r_grant  <= w_grant;
            r_paddr  <= w_paddr;
            r_pwdata <= w_pwdata;
            r_pwrite <= w_pwrite;
            r_rdata  <= w_rdata;
            r_err    <= w_err;
`ifdef APB_TIMEOUT_EN
            r_tcnt   <= w_tcnt;
`endif
        end
    end
    always_comb begin
        w_state  = r_state;
        w_last   = r_last;
        w_grant  = r_grant;
        w_paddr  = r_paddr;
        w_pwdata = r_pwdata;
        w_pwrite = r_pwrite;
        w_rdata  = r_rdata;
        w_err    = r_err;
`ifdef APB_TIMEOUT_EN
        w_tcnt   = r_tcnt;
`endif
        // Port 1 wins when alone, or when both ask and port 0 was served last.
        w_win    = bus.req1 & (~bus.req0 | ~r_last);
        case (r_state)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    w_state  = SETUP;
                    w_last   = w_win;
                    w_grant  = w_win ? 2'b10 : 2'b01;
                    w_paddr  = w_win ? bus.addr1 : bus.addr0;
                    w_pwdata = w_win ? bus.wdata1 : bus.wdata0;
                    w_pwrite = w_win ? bus.write1 : bus.write0;
                end
            end
            SETUP: begin
                w_state = ACCESS;
`ifdef APB_TIMEOUT_EN
                w_tcnt  = '0;
`endif
            end
            ACCESS: begin
                if (bus.pready) begin
                    w_state = DONE;
                    w_rdata = r_pwrite ? '0 : bus.prdata;
                    w_err   = bus.pslverr;
                end
`ifdef APB_TIMEOUT_EN
                else if (r_tcnt == TO_LIM) begin
                    w_state = DONE;
                    w_rdata = '0;
                    w_err   = 1'b1;
                end else begin
                    w_tcnt = r_tcnt + 10'd1;
                end
`endif
            end
            DONE: begin
                w_state = IDLE;
                w_grant = '0;
            end
            default: w_state = IDLE;
        endcase
    end
    assign w_slot      = r_paddr[SLOT_LSB+3:SLOT_LSB];
    assign w_ack0      = (r_state == DONE) & r_grant[0];
    assign w_ack1      = (r_state == DONE) & r_grant[1];
    assign bus.psel    = (r_state == SETUP || r_state == ACCESS) ? 16'd1 << w_slot : '0;
    assign bus.penable = r_state == ACCESS;
    assign bus.paddr   = r_paddr;
    assign bus.pwdata  = r_pwdata;
    assign bus.pwrite  = r_pwrite;
    assign bus.grant   = r_grant;
    assign bus.ack0    = w_ack0;
    assign bus.ack1    = w_ack1;
    assign bus.rdata0  = w_ack0 ? r_rdata : '0;
    assign bus.rdata1  = w_ack1 ? r_rdata : '0;
    assign bus.err0    = w_ack0 & r_err;
    assign bus.err1    = w_ack1 & r_err;
endmodule

// File: tb/tb_apb_dual_master_arbiter.sv
// tb_apb_dual_master_arbiter: directed self-checking bench for apb_dual_master_arbiter
module tb_apb_dual_master_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    apb_dual_master_arbiter_if bus ();
    apb_dual_master_arbiter #(.SLOT_LSB(24), .TIMEOUT_CYCLES(4)) dut (
        .i_pclk(clk),
        .i_presetn(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic idle_inputs();
        bus.req0 = 0; bus.req1 = 0; bus.write0 = 0; bus.write1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        bus.prdata = 0; bus.pready = 0; bus.pslverr = 0;
    endtask
    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        n_tests++;
        if (bus.psel !== 16'h0 || bus.penable !== 1'b0 || bus.grant !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_bus psel=%h penable=%b grant=%b required 0/0/0", bus.psel, bus.penable, bus.grant);
        end
        n_tests++;
        if ({bus.ack0, bus.ack1, bus.err0, bus.err1} !== 4'b0 || bus.rdata0 !== 32'h0 || bus.rdata1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_resp ack=%b%b err=%b%b rdata0=%h rdata1=%h required 0", bus.ack0, bus.ack1, bus.err0, bus.err1, bus.rdata0, bus.rdata1);
        end
        n_tests++;
        if (bus.paddr !== 32'h0 || bus.pwdata !== 32'h0 || bus.pwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_latch paddr=%h pwdata=%h pwrite=%b required 0", bus.paddr, bus.pwdata, bus.pwrite);
        end
        rst_n = 1;
    endtask
    task automatic test_read0();
        bus.req0 = 1; bus.write0 = 0; bus.addr0 = 32'h0300_0010;
        bus.pready = 1; bus.prdata = 32'hCAFE_F00D;
        @(negedge clk);
        n_tests++;
        if (bus.psel !== 16'h0008 || bus.penable !== 1'b0 || bus.grant !== 2'b01 || bus.paddr !== 32'h0300_0010 || bus.ack0 !== 1'b0) begin
            n_fail++;
            $display("FAIL read0_setup psel=%h penable=%b grant=%b paddr=%h ack0=%b required 0008/0/01/03000010/0", bus.psel, bus.penable, bus.grant, bus.paddr, bus.ack0);
        end
        @(negedge clk);
        n_tests++;
        if (bus.psel !== 16'h0008 || bus.penable !== 1'b1 || bus.pwrite !== 1'b0 || bus.ack0 !== 1'b0) begin
            n_fail++;
            $display("FAIL read0_access psel=%h penable=%b pwrite=%b ack0=%b required 0008/1/0/0", bus.psel, bus.penable, bus.pwrite, bus.ack0);
        end
        @(negedge clk);
        n_tests++;
        if (bus.ack0 !== 1'b1 || bus.rdata0 !== 32'hCAFE_F00D || bus.err0 !== 1'b0 || bus.psel !== 16'h0 || bus.penable !== 1'b0) begin
            n_fail++;
            $display("FAIL read0_done ack0=%b rdata0=%h err0=%b psel=%h penable=%b required 1/cafef00d/0/0000/0", bus.ack0, bus.rdata0, bus.err0, bus.psel, bus.penable);
        end
        n_tests++;
        if (bus.ack1 !== 1'b0 || bus.rdata1 !== 32'h0 || bus.err1 !== 1'b0) begin
            n_fail++;
            $display("FAIL read0_other ack1=%b rdata1=%h err1=%b required 0", bus.ack1, bus.rdata1, bus.err1);
        end
        bus.req0 = 0;
        @(negedge clk);
        n_tests++;
        if (bus.ack0 !== 1'b0 || bus.rdata0 !== 32'h0 || bus.grant !== 2'b00) begin
            n_fail++;
            $display("FAIL read0_after ack0=%b rdata0=%h grant=%b required 0/0/00", bus.ack0, bus.rdata0, bus.grant);
        end
    endtask
    task automatic test_write1_wait();
        bus.req1 = 1; bus.write1 = 1; bus.addr1 = 32'h0F00_0004; bus.wdata1 = 32'h1234_5678;
        bus.pready = 0; bus.prdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_tests++;
        if (bus.psel !== 16'h8000 || bus.penable !== 1'b0 || bus.pwrite !== 1'b1 || bus.pwdata !== 32'h1234_5678 || bus.grant !== 2'b10) begin
            n_fail++;
            $display("FAIL write1_setup psel=%h penable=%b pwrite=%b pwdata=%h grant=%b required 8000/0/1/12345678/10", bus.psel, bus.penable, bus.pwrite, bus.pwdata, bus.grant);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.psel !== 16'h8000 || bus.penable !== 1'b1 || bus.pwdata !== 32'h1234_5678 || bus.paddr !== 32'h0F00_0004 || bus.ack1 !== 1'b0) begin
                n_fail++;
                $display("FAIL write1_access%0d psel=%h penable=%b pwdata=%h paddr=%h ack1=%b required 8000/1/12345678/0f000004/0", i, bus.psel, bus.penable, bus.pwdata, bus.paddr, bus.ack1);
            end
            if (i == 3) bus.pready = 1;
        end
        @(negedge clk);
        n_tests++;
        if (bus.ack1 !== 1'b1 || bus.rdata1 !== 32'h0 || bus.err1 !== 1'b0 || bus.ack0 !== 1'b0 || bus.psel !== 16'h0) begin
            n_fail++;
            $display("FAIL write1_done ack1=%b rdata1=%h err1=%b ack0=%b psel=%h required 1/0/0/0/0000", bus.ack1, bus.rdata1, bus.err1, bus.ack0, bus.psel);
        end
        bus.req1 = 0; bus.write1 = 0;
        @(negedge clk);
        n_tests++;
        if (bus.ack1 !== 1'b0 || bus.grant !== 2'b00) begin
            n_fail++;
            $display("FAIL write1_after ack1=%b grant=%b required 0/00", bus.ack1, bus.grant);
        end
    endtask
    task automatic test_contention();
        logic [1:0] exp_grant, exp_ack;
        int p, x;
        test_reset();
        bus.addr0 = 32'h0100_0000; bus.addr1 = 32'h0200_0000; bus.pready = 1; bus.prdata = 32'h5555_AAAA;
        bus.req0 = 1; bus.req1 = 1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            p = (k - 1) % 4;
            x = (k - 1) / 4;
            exp_grant = (p == 3) ? 2'b00 : ((x % 2) ? 2'b10 : 2'b01);
            exp_ack = (p == 2) ? ((x % 2) ? 2'b10 : 2'b01) : 2'b00;
            n_tests++;
            if (bus.grant !== exp_grant || {bus.ack1, bus.ack0} !== exp_ack) begin
                n_fail++;
                $display("FAIL contention_c%0d grant=%b ack10=%b%b required grant=%b ack10=%b", k, bus.grant, bus.ack1, bus.ack0, exp_grant, exp_ack);
            end
        end
        bus.req0 = 0; bus.req1 = 0;
        @(negedge clk);
    endtask
    task automatic test_slverr();
        bus.req0 = 1; bus.write0 = 0; bus.addr0 = 32'h0300_0000; bus.pready = 1; bus.pslverr = 1; bus.prdata = 32'h0000_0011;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.ack0 !== 1'b1 || bus.err0 !== 1'b1 || bus.rdata0 !== 32'h0000_0011) begin
            n_fail++;
            $display("FAIL slverr_err ack0=%b err0=%b rdata0=%h required 1/1/00000011", bus.ack0, bus.err0, bus.rdata0);
        end
        bus.req0 = 0; bus.pslverr = 0;
        @(negedge clk);
        n_tests++;
        if (bus.err0 !== 1'b0 || bus.ack0 !== 1'b0) begin
            n_fail++;
            $display("FAIL slverr_clear err0=%b ack0=%b required 0/0", bus.err0, bus.ack0);
        end
        bus.req0 = 1; bus.prdata = 32'h0000_0022;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.ack0 !== 1'b1 || bus.err0 !== 1'b0 || bus.rdata0 !== 32'h0000_0022) begin
            n_fail++;
            $display("FAIL slverr_next ack0=%b err0=%b rdata0=%h required 1/0/00000022", bus.ack0, bus.err0, bus.rdata0);
        end
        bus.req0 = 0;
        @(negedge clk);
    endtask
    task automatic test_reset_mid();
        bus.req0 = 1; bus.write0 = 0; bus.addr0 = 32'h0500_0000; bus.pready = 0; bus.prdata = 32'h7777_0000;
        repeat (3) @(negedge clk);
        #1 rst_n = 0;
        #1;
        n_tests++;
        if (bus.psel !== 16'h0 || bus.penable !== 1'b0 || bus.grant !== 2'b00 || bus.ack0 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async psel=%h penable=%b grant=%b ack0=%b required 0", bus.psel, bus.penable, bus.grant, bus.ack0);
        end
        @(negedge clk);
        n_tests++;
        if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_noack ack0=%b ack1=%b required 0", bus.ack0, bus.ack1);
        end
        @(negedge clk);
        rst_n = 1; bus.pready = 1;
        @(negedge clk);
        n_tests++;
        if (bus.grant !== 2'b01 || bus.psel !== 16'h0020 || bus.penable !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_setup grant=%b psel=%h penable=%b required 01/0020/0", bus.grant, bus.psel, bus.penable);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.ack0 !== 1'b1 || bus.rdata0 !== 32'h7777_0000) begin
            n_fail++;
            $display("FAIL midrst_serve ack0=%b rdata0=%h required 1/77770000", bus.ack0, bus.rdata0);
        end
        bus.req0 = 0;
        @(negedge clk);
    endtask
    task automatic test_timeout();
        bus.req0 = 1; bus.write0 = 0; bus.addr0 = 32'h0300_0000; bus.pready = 0; bus.prdata = 32'hFFFF_FFFF;
`ifdef APB_TIMEOUT_EN
        repeat (5) @(negedge clk);
        n_tests++;
        if (bus.ack0 !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early ack0=%b required 0", bus.ack0);
        end
        @(negedge clk);
        n_tests++;
        if (bus.ack0 !== 1'b1 || bus.err0 !== 1'b1 || bus.rdata0 !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout_done ack0=%b err0=%b rdata0=%h required 1/1/0", bus.ack0, bus.err0, bus.rdata0);
        end
        bus.req0 = 0;
        @(negedge clk);
`else
        begin
            logic seen;
            seen = 0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                seen = seen | bus.ack0;
            end
            n_tests++;
            if (seen !== 1'b0 || bus.penable !== 1'b1) begin
                n_fail++;
                $display("FAIL no_timeout ack_seen=%b penable=%b required 0/1", seen, bus.penable);
            end
        end
        bus.req0 = 0;
        test_reset();
`endif
    endtask
    initial begin
        test_reset();
        test_read0();
        test_write1_wait();
        test_contention();
        test_slverr();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
